// File: rtl/rc_pulse_shaper_tx.sv
// -----------------------------------------------------------------------------
// rc_pulse_shaper_tx
//
// Raised-cosine pulse-shaping transmitter. One coded word is accepted and
// serialised MSB first into BPSK (BPS=1) or Gray-coded 4-PAM (BPS=2) symbols.
// Each symbol is upsampled by SPS (one impulse followed by SPS-1 zeros) and
// filtered by an NTAPS-tap FIR whose coefficients can be rewritten while idle.
// After the last symbol, NTAPS-1 zero inputs flush the filter tail. Samples
// leave through a valid/ready interface that may stall at any time.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   in_data     coded word to transmit
//   in_valid    in_data valid
//   in_ready    block can accept a word (high only while idle)
//   coef_we     coefficient write strobe (honoured only while idle)
//   coef_addr   tap index; indices >= NTAPS are ignored
//   coef_data   signed coefficient
//   out_data    signed, saturated output sample
//   out_valid   out_data valid
//   out_ready   downstream accepts the sample
//   out_last    marks the final sample of a frame
//   busy        frame in progress
//   frame_done  one-cycle pulse after the last-sample handshake
// -----------------------------------------------------------------------------
module rc_pulse_shaper_tx #(
    parameter int DATA_W = 21,
    parameter int BPS    = 1,
    parameter int SPS    = 8,
    parameter int NTAPS  = 33,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int NSYM    = DATA_W / BPS;
    localparam int RUN_LEN = NSYM * SPS;
    localparam int NTOT    = RUN_LEN + NTAPS - 1;
    localparam int CNT_W   = $clog2(NTOT + 1);
    localparam int PH_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int LVL_W   = 3;  // holds -3..+3
    localparam int ACC_W   = COEF_W + LVL_W + $clog2(NTAPS);
    localparam int CENTER  = (NTAPS - 1) / 2;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [LVL_W-1:0]  lvl_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t DEF_TAP = coef_t'(2 ** (OUT_W - 3));
    localparam acc_t  SAT_MAX = acc_t'((2 ** (OUT_W - 1)) - 1);
    localparam acc_t  SAT_MIN = acc_t'(-(2 ** (OUT_W - 1)));

    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] NTOT_LAST = CNT_W'(NTOT - 1);
    localparam logic [CNT_W-1:0] NTOT_CNT  = CNT_W'(NTOT);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   word_q;      // remaining symbol bits, next symbol at the top
    logic [CNT_W-1:0]    n_q;         // samples already shifted into the delay line
    logic [PH_W-1:0]     phase_q;     // n mod SPS
    logic                s1_valid_q;  // delay line holds a sample not yet output
    logic                s1_last_q;   // ... and it is the final one of the frame
    coef_t               coef_q [NTAPS];
    lvl_t                dly_q  [NTAPS];

    logic                accept;
    logic                advance;
    logic                gen_active;
    logic                gen_step;
    logic                coef_wr;
    lvl_t                sym_lvl;
    lvl_t                x_in;
    acc_t                acc;
    logic [OUT_W-1:0]    sat;

    assign accept     = (state_q == S_IDLE) && in_valid;
    // Output register may take a new value when empty or being drained.
    assign advance    = !out_valid || out_ready;
    assign gen_active = (state_q != S_IDLE) && (n_q != NTOT_CNT);
    assign gen_step   = advance && gen_active;
    assign coef_wr    = (state_q == S_IDLE) && coef_we && (int'(coef_addr) < NTAPS);

    // Symbol level of the bits at the top of word_q, and the upsampled input.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        sym_lvl = '0;
        x_in    = '0;
        if (BPS == 1) begin
            sym_lvl = word_q[DATA_W-1] ? lvl_t'(1) : lvl_t'(-1);
        end else begin
            case ({word_q[DATA_W-1], word_q[DATA_W-2]})
                2'b00:   sym_lvl = lvl_t'(-3);
                2'b01:   sym_lvl = lvl_t'(-1);
                2'b11:   sym_lvl = lvl_t'(1);
                default: sym_lvl = lvl_t'(3);
            endcase
        end
        if ((state_q == S_RUN) && (phase_q == '0)) begin
            x_in = sym_lvl;
        end
    end

    // Full-precision FIR over the delay line; dly_q[0] is the newest input.
    always_comb begin
        acc = '0;
        for (int j = 0; j < NTAPS; j++) begin
            acc = acc + acc_t'(coef_q[j]) * acc_t'(dly_q[j]);
        end
    end

    always_comb begin
        sat = acc[OUT_W-1:0];
        if (acc > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (acc < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (gen_step && (n_q == RUN_LAST)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (out_valid && out_ready && out_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Two-stage datapath: the delay line holds the sample being formed, the
    // output register holds the one on offer. Both advance together, so a
    // stall freezes the whole pipeline and nothing is lost or repeated.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q     <= '0;
            n_q        <= '0;
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            // NOTE: the tap array and delay line are reset on purpose: reset
            // must restore the default taps and an empty filter, so these are
            // flops rather than a RAM.
            for (int j = 0; j < NTAPS; j++) begin
                dly_q[j]  <= '0;
                coef_q[j] <= (j == CENTER) ? DEF_TAP : '0;
            end
        end else begin
            frame_done <= out_valid && out_ready && out_last;

            if (coef_wr) begin
                coef_q[coef_addr] <= coef_t'(coef_data);
            end

            if (accept) begin
                word_q     <= in_data;
                n_q        <= '0;
                phase_q    <= '0;
                s1_valid_q <= 1'b0;
                s1_last_q  <= 1'b0;
                for (int j = 0; j < NTAPS; j++) begin
                    dly_q[j] <= '0;
                end
            end else if ((state_q != S_IDLE) && advance) begin
                out_data  <= sat;
                out_valid <= s1_valid_q;
                out_last  <= s1_valid_q && s1_last_q;
                if (gen_active) begin
                    dly_q[0] <= x_in;
                    for (int j = 1; j < NTAPS; j++) begin
                        dly_q[j] <= dly_q[j-1];
                    end
                    s1_valid_q <= 1'b1;
                    s1_last_q  <= (n_q == NTOT_LAST);
                    n_q        <= n_q + 1'b1;
                    phase_q    <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                    if ((state_q == S_RUN) && (phase_q == '0)) begin
                        word_q <= word_q << BPS;
                    end
                end else begin
                    s1_valid_q <= 1'b0;
                    s1_last_q  <= 1'b0;
                end
            end
        end
    end

endmodule
